// File: rtl/mdu_if.sv
// Handshake and result bundle between the execute-stage control and the
// iterative multiply/divide unit.
interface mdu_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [5:0]        funct;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, funct, rs_val, rt_val, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, funct, rs_val, rt_val, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Define MDU_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier.
module mdu_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic   clk,
  input logic   rst,
  mdu_if.slave  bus
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state_q, state_d;

  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   opnd_q;
  logic [DATA_W-1:0]   src_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mul_q;
  logic                neg_lo_q;
  logic                neg_hi_q;
  logic                dz_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                done_q;

  logic is_mul, is_div, is_signed, accept, launch, last;
  logic [DATA_W-1:0] a_abs, b_abs;

  always_comb begin
    is_mul    = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
    is_div    = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
    is_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
    accept    = bus.start && !bus.flush && (state_q == IDLE);
    launch    = accept && (is_mul || is_div);
    last      = (cnt_q == CNT_W'(DATA_W - 1));
    a_abs     = (is_signed && bus.rs_val[DATA_W-1]) ? -bus.rs_val : bus.rs_val;
    b_abs     = (is_signed && bus.rt_val[DATA_W-1]) ? -bus.rt_val : bus.rt_val;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
`ifdef MDU_FAST_MUL_EN
          state_d = is_mul ? FIN : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (bus.flush)  state_d = IDLE;
        else if (last)  state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Multiply keeps {partial product, remaining multiplier bits} in acc;
  // divide keeps {partial remainder, dividend bits turning into quotient}.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [2*DATA_W-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
    div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_next  = {(div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                 acc_q[DATA_W-2:0], div_ge};
  end

  logic [2*DATA_W-1:0] prod_raw, prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  always_comb begin
`ifdef MDU_FAST_MUL_EN
    // Fast path never enters CALC, so acc low half still holds |multiplier|.
    prod_raw = {{DATA_W{1'b0}}, opnd_q} * {{DATA_W{1'b0}}, acc_q[DATA_W-1:0]};
`else
    prod_raw = acc_q;
`endif
    prod_fix = neg_lo_q ? -prod_raw : prod_raw;
    quot_fix = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      src_q    <= '0;
      cnt_q    <= '0;
      mul_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept && bus.funct == F_MTHI) hi_q <= bus.rs_val;
          if (accept && bus.funct == F_MTLO) lo_q <= bus.rs_val;
          if (launch) begin
            cnt_q  <= '0;
            mul_q  <= is_mul;
            src_q  <= bus.rs_val;
            dz_q   <= is_div && (bus.rt_val == '0);
            opnd_q <= is_mul ? a_abs : b_abs;
            acc_q  <= {{DATA_W{1'b0}}, (is_mul ? b_abs : a_abs)};
            neg_lo_q <= is_signed && (bus.rs_val[DATA_W-1] ^ bus.rt_val[DATA_W-1]);
            neg_hi_q <= is_signed && bus.rs_val[DATA_W-1];
          end
        end
        CALC: begin
          if (!bus.flush) begin
            acc_q <= mul_q ? mul_next : div_next;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (mul_q) begin
              hi_q <= prod_fix[2*DATA_W-1:DATA_W];
              lo_q <= prod_fix[DATA_W-1:0];
            end else if (dz_q) begin
              hi_q <= src_q;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_mdu_iter;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_if #(.DATA_W(32)) bus ();
  mdu_iter #(.DATA_W(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = {exp_hi, exp_lo};
    case (f)
      F_MULT: begin
        p = sa * sb;
        res = p;
      end
      F_MULTU: res = {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
      default: ;
    endcase
    return res;
  endfunction

  function automatic int exp_latency(input logic [5:0] f);
`ifdef MDU_FAST_MUL_EN
    if (f == F_MULT || f == F_MULTU) return 1;
`endif
    return 33;
  endfunction

  task automatic drive_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct  = f;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int k;
    bit busy_ok;
    e = model(f, a, b);
    drive_start(f, a, b);
    check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    k = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && k < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(exp_latency(f)));
    check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, " hi"}, bus.hi, e[63:32]);
    check({tag, " lo"}, bus.lo, e[31:0]);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    @(posedge clk); #1;
    check({tag, " done_pulse_end"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [5:0] fset [4];
    logic [5:0] f;
    logic [31:0] a, b;
    int k, dones, first_k;
    logic [63:0] e;

    fset[0] = F_MULT; fset[1] = F_MULTU; fset[2] = F_DIV; fset[3] = F_DIVU;
    bus.start = 1'b0; bus.funct = '0; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mult_neg3x7", F_MULT, 32'hFFFFFFFD, 32'd7);
    check("mult_neg3x7 hi_const", exp_hi, 32'hFFFFFFFF);
    check("mult_neg3x7 lo_const", exp_lo, 32'hFFFFFFEB);
    run_op("multu_max_x2", F_MULTU, 32'hFFFFFFFF, 32'd2);
    run_op("div_neg7_2", F_DIV, 32'hFFFFFFF9, 32'd2);
    run_op("divu_by_zero", F_DIVU, 32'd100, 32'd0);
    run_op("div_by_zero_neg", F_DIV, 32'hFFFFFF00, 32'd0);
    run_op("div_overflow", F_DIV, 32'h80000000, 32'hFFFFFFFF);
    run_op("mult_6x7", F_MULT, 32'd6, 32'd7);
    run_op("mult_min_min", F_MULT, 32'h80000000, 32'h80000000);

    // MTHI / MTLO
    drive_start(F_MTHI, 32'h12345678, 32'd0);
    check("mthi hi", bus.hi, 32'h12345678);
    check("mthi busy", 32'(bus.busy), 32'd0);
    check("mthi done", 32'(bus.done), 32'd0);
    exp_hi = 32'h12345678;
    drive_start(F_MTLO, 32'h9, 32'd0);
    check("mtlo lo", bus.lo, 32'h9);
    check("mtlo hi_kept", bus.hi, exp_hi);
    check("mtlo busy", 32'(bus.busy), 32'd0);
    check("mtlo done", 32'(bus.done), 32'd0);
    exp_lo = 32'h9;

    // unknown funct ignored
    drive_start(6'b100000, 32'hDEADBEEF, 32'd3);
    check("bad_funct busy", 32'(bus.busy), 32'd0);
    check("bad_funct hi", bus.hi, exp_hi);
    check("bad_funct lo", bus.lo, exp_lo);

    // flush during CALC
    drive_start(F_DIV, 32'd1000, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1; bus.flush = 1'b0;
    check("flush busy", 32'(bus.busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    check("flush no_done", 32'(dones), 32'd0);
    check("flush hi", bus.hi, exp_hi);
    check("flush lo", bus.lo, exp_lo);

    // flush together with start in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct = F_MULT; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start busy", 32'(bus.busy), 32'd0);

    // second start while busy is ignored
    e = model(F_DIV, 32'd12345, 32'd10);
    drive_start(F_DIV, 32'd12345, 32'd10);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    bus.start = 1'b1; bus.funct = F_MULT; bus.rs_val = 32'd3; bus.rt_val = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 5; dones = 0; first_k = -1;
    while (k < 80) begin
      if (bus.done === 1'b1) begin
        dones++;
        if (first_k < 0) first_k = k;
      end
      @(posedge clk); #1;
      k++;
    end
    check("busy_start done_count", 32'(dones), 32'd1);
    check("busy_start latency", 32'(first_k), 32'd33);
    check("busy_start hi", bus.hi, e[63:32]);
    check("busy_start lo", bus.lo, e[31:0]);
    exp_hi = e[63:32]; exp_lo = e[31:0];

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      f = fset[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
      run_op($sformatf("rand%0d", i), f, a, b);
    end

    // reset mid-operation
    drive_start(F_MULTU, 32'hABCDEF01, 32'h12345);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst hi", bus.hi, 32'd0);
    check("midrst lo", bus.lo, 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    @(negedge clk); rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    run_op("post_rst_divu", F_DIVU, 32'hFFFFFFFF, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
